// File: rtl/imem_loader.sv
// Boot-time loader: turns a counted little-endian byte stream into sequential
// 32-bit instruction-memory writes, holding the CPU until the image is loaded.
module imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int MAX_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // One extra bit so a full 2^ADDR_W image does not wrap the word index.
  localparam int IW = ADDR_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

  logic [2:0]    state;
  logic [IW-1:0] word_idx;
  logic [IW-1:0] last_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   asm_lo;
  logic          xfer;
  logic          hdr_bad;

  // Handshake: a byte moves on a rising edge where rx_valid && rx_ready;
  // rx_ready is a pure decode of state and never depends on rx_valid.
  assign rx_ready  = (state == S_IDLE) || (state == S_LOAD);
  assign xfer      = rx_valid && rx_ready;
  assign hdr_bad   = (rx_data == 8'd0) || (rx_data > MAX_N);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      word_idx <= '0;
      last_idx <= '0;
      byte_idx <= 2'd0;
      asm_lo   <= 24'd0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= 32'd0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer) begin
            if (hdr_bad) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              // Storing N-1 lets the WRITE state compare directly against the index.
              last_idx <= IW'(rx_data - 8'd1);
              word_idx <= '0;
              byte_idx <= 2'd0;
              state    <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: asm_lo[7:0]   <= rx_data;
              2'd1: asm_lo[15:8]  <= rx_data;
              2'd2: asm_lo[23:16] <= rx_data;
              default: begin
                // Top lane goes straight into the write word.
                we    <= 1'b1;
                waddr <= word_idx[ADDR_W-1:0];
                wdata <= {rx_data, asm_lo};
                state <= S_WRITE;
              end
            endcase
          end
        end

        S_WRITE: begin
          word_idx <= word_idx + 1'b1;
          if (word_idx == last_idx) begin
            state    <= S_DONE;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
          end else begin
            state <= S_LOAD;
          end
        end

        S_DONE: state <= S_DONE;

        S_ERR: state <= S_ERR;

        default: state <= S_IDLE;
      endcase
    end
  end

  a_we_single : assert property (@(posedge clk) disable iff (reset) we |=> !we);
  a_we_not_done : assert property (@(posedge clk) disable iff (reset) we |-> !done);
  a_write_no_ready : assert property (@(posedge clk) disable iff (reset)
    (state == S_WRITE) |-> !rx_ready);
  a_addr_in_range : assert property (@(posedge clk) disable iff (reset)
    we |-> ({1'b0, waddr} <= last_idx));
  a_done_releases : assert property (@(posedge clk) disable iff (reset) done |-> !cpu_hold);
  a_err_holds : assert property (@(posedge clk) disable iff (reset) err |-> (cpu_hold && !done));

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: each task drives one scenario and checks
// outputs against hand-computed values, then a single summary line is printed.
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cyc = -1;
  int overlap = 0;
  int last_acc_cyc = 0;

  logic [5:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  imem_loader #(.ADDR_W(6), .MAX_WORDS(64)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (we) begin
      wr_addr_q.push_back(waddr);
      wr_data_q.push_back(wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (we && done) overlap++;
    if (done && done_cyc < 0) done_cyc = cyc;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end at a falling edge
  task automatic pulse_reset();
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_test();
    pulse_reset();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    done_cyc = -1;
    overlap = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit accepted;
    accepted = 1'b0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 40 && !accepted; i++) begin
      if (rx_ready) accepted = 1'b1;
      @(negedge clk);
    end
    if (accepted) begin
      last_acc_cyc = cyc;
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: byte %h not accepted, got rx_ready=%b, expected 1", b, rx_ready);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Scenario tasks
  task automatic test_reset();
    start_test();
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b expected 1", rx_ready); end
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", we); end
    checks++; if (waddr !== 6'd0) begin errors++; $display("FAIL reset_waddr: got %h expected 00", waddr); end
    checks++; if (wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata: got %h expected 00000000", wdata); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold: got %b expected 1", cpu_hold); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_two_words();
    int hdr_cyc;
    start_test();
    send_byte(8'h02, 0);
    hdr_cyc = last_acc_cyc;
    checks++; if (rx_ready !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL hdr_load_state: got rx_ready=%b cpu_hold=%b expected 1 1", rx_ready, cpu_hold);
    end
    send_word(32'hE04F000F, 1'b0);
    send_word(32'hE04F100F, 1'b0);
    idle(6);
    checks++; if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL two_write_count: got %0d expected 2", wr_addr_q.size());
    end else begin
      checks++; if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'hE04F000F) begin
        errors++; $display("FAIL two_word0: got %h/%h expected 00/E04F000F", wr_addr_q[0], wr_data_q[0]);
      end
      checks++; if (wr_addr_q[1] !== 6'd1 || wr_data_q[1] !== 32'hE04F100F) begin
        errors++; $display("FAIL two_word1: got %h/%h expected 01/E04F100F", wr_addr_q[1], wr_data_q[1]);
      end
      checks++; if (wr_cyc_q[0] !== hdr_cyc + 4) begin
        errors++; $display("FAIL first_write_latency: got cycle %0d expected %0d", wr_cyc_q[0], hdr_cyc + 4);
      end
      checks++; if (wr_cyc_q[1] - wr_cyc_q[0] !== 5) begin
        errors++; $display("FAIL write_spacing: got %0d expected 5", wr_cyc_q[1] - wr_cyc_q[0]);
      end
      checks++; if (done_cyc !== wr_cyc_q[1] + 1) begin
        errors++; $display("FAIL done_timing: got cycle %0d expected %0d", done_cyc, wr_cyc_q[1] + 1);
      end
    end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL two_final: got done=%b cpu_hold=%b rx_ready=%b expected 1 0 0", done, cpu_hold, rx_ready);
    end
    checks++; if (overlap !== 0) begin
      errors++; $display("FAIL we_with_done: got %0d overlaps expected 0", overlap);
    end
  endtask

  task automatic test_bad_header(input logic [7:0] h);
    int bad_ready;
    start_test();
    send_byte(h, 0);
    rx_valid = 1'b0;
    checks++; if (err !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
      errors++; $display("FAIL bad_hdr_%h: got err=%b cpu_hold=%b done=%b rx_ready=%b expected 1 1 0 0", h, err, cpu_hold, done, rx_ready);
    end
    bad_ready = 0;
    rx_valid = 1'b1;
    rx_data  = 8'h04;
    repeat (6) begin
      @(negedge clk);
      if (rx_ready !== 1'b0 || err !== 1'b1 || cpu_hold !== 1'b1) bad_ready++;
    end
    rx_valid = 1'b0;
    checks++; if (bad_ready !== 0) begin
      errors++; $display("FAIL bad_hdr_%h_hold: got %0d bad cycles expected 0", h, bad_ready);
    end
    checks++; if (wr_addr_q.size() !== 0) begin
      errors++; $display("FAIL bad_hdr_%h_writes: got %0d expected 0", h, wr_addr_q.size());
    end
  endtask

  task automatic test_gaps();
    start_test();
    send_byte(8'h01, 0);
    send_word(32'hE1A00000, 1'b1);
    idle(4);
    checks++; if (wr_addr_q.size() !== 1) begin
      errors++; $display("FAIL gap_write_count: got %0d expected 1", wr_addr_q.size());
    end else begin
      checks++; if (wr_addr_q[0] !== 6'd0 || wr_data_q[0] !== 32'hE1A00000) begin
        errors++; $display("FAIL gap_word: got %h/%h expected 00/E1A00000", wr_addr_q[0], wr_data_q[0]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL gap_done: got %b expected 1", done); end
  endtask

  task automatic test_reset_mid();
    start_test();
    send_byte(8'h02, 0);
    send_word(32'hE04F000F, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    idle(2);
    checks++; if (wr_addr_q.size() !== 1) begin
      errors++; $display("FAIL mid_pre_writes: got %0d expected 1", wr_addr_q.size());
    end
    pulse_reset();
    checks++; if (rx_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL mid_after_reset: got rx_ready=%b cpu_hold=%b done=%b expected 1 1 0", rx_ready, cpu_hold, done);
    end
    send_byte(8'h01, 0);
    send_word(32'hE2811001, 1'b0);
    idle(4);
    checks++; if (wr_addr_q.size() !== 2) begin
      errors++; $display("FAIL mid_write_count: got %0d expected 2", wr_addr_q.size());
    end else begin
      checks++; if (wr_addr_q[1] !== 6'd0 || wr_data_q[1] !== 32'hE2811001) begin
        errors++; $display("FAIL mid_new_word: got %h/%h expected 00/E2811001", wr_addr_q[1], wr_data_q[1]);
      end
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b expected 1", done); end
  endtask

  task automatic test_full_64();
    int bad_addr;
    int bad_data;
    start_test();
    send_byte(8'h40, 0);
    for (int i = 0; i < 64; i++) begin
      send_word(32'(i), 1'b0);
      if (i == 62) begin
        checks++; if (done !== 1'b0) begin
          errors++; $display("FAIL full_early_done: got %b expected 0", done);
        end
      end
    end
    idle(4);
    checks++; if (wr_addr_q.size() !== 64) begin
      errors++; $display("FAIL full_write_count: got %0d expected 64", wr_addr_q.size());
    end else begin
      bad_addr = 0;
      bad_data = 0;
      for (int i = 0; i < 64; i++) begin
        if (wr_addr_q[i] !== 6'(i)) bad_addr++;
        if (wr_data_q[i] !== 32'(i)) bad_data++;
      end
      checks++; if (bad_addr !== 0) begin errors++; $display("FAIL full_addr_order: got %0d wrong expected 0", bad_addr); end
      checks++; if (bad_data !== 0) begin errors++; $display("FAIL full_data: got %0d wrong expected 0", bad_data); end
      checks++; if (wr_data_q[63] !== 32'h0000003F) begin
        errors++; $display("FAIL full_last_word: got %h expected 0000003F", wr_data_q[63]);
      end
      checks++; if (done_cyc !== wr_cyc_q[63] + 1) begin
        errors++; $display("FAIL full_done_timing: got cycle %0d expected %0d", done_cyc, wr_cyc_q[63] + 1);
      end
    end
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin
      errors++; $display("FAIL full_final: got done=%b cpu_hold=%b expected 1 0", done, cpu_hold);
    end
  endtask

  task automatic test_after_done();
    int n_before;
    int bad;
    n_before = wr_addr_q.size();
    bad = 0;
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (10) begin
      @(negedge clk);
      if (rx_ready !== 1'b0 || done !== 1'b1 || cpu_hold !== 1'b0) bad++;
    end
    rx_valid = 1'b0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL after_done_hold: got %0d bad cycles expected 0", bad); end
    checks++; if (wr_addr_q.size() !== n_before) begin
      errors++; $display("FAIL after_done_writes: got %0d expected %0d", wr_addr_q.size(), n_before);
    end
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_two_words();
    test_bad_header(8'h00);
    test_bad_header(8'h41);
    test_gaps();
    test_reset_mid();
    test_full_64();
    test_after_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills the writable instruction memory from a byte stream before the pipeline runs. It accepts a word-count header byte followed by little-endian instruction bytes, assembles 32-bit words, and issues one write per word at consecutive word addresses starting at 0. It holds the CPU in reset until the load completes. It is the write-side counterpart of the instruction memory that the fetch stage reads.

## Interface
- `ADDR_W`, default 6: word-address width; must match the instruction memory depth of 64 words.
- `MAX_WORDS`, default 64: largest legal word count; must be ≤ 2^ADDR_W and ≤ 255.

- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high.
- `rx_valid`, in, 1: byte on `rx_data` is valid.
- `rx_data`, in, 8: stream byte.
- `rx_ready`, out, 1: loader can accept a byte this cycle.
- `we`, out, 1: instruction-memory write enable, one-cycle pulse.
- `waddr`, out, ADDR_W: word address of the write.
- `wdata`, out, 32: instruction word being written.
- `cpu_hold`, out, 1: holds the CPU reset/stall while high.
- `done`, out, 1: load completed successfully (sticky).
- `err`, out, 1: illegal header seen (sticky).

## Operation
- Byte transfer occurs at a rising edge with `rx_valid && rx_ready`. `rx_data` is ignored otherwise.
- Stream format: byte 0 is N, the word count. It is followed by 4·N bytes, least-significant byte first. Example: word E04F000F is sent as 0F, 00, 4F, E0.
- FSM states:
  - IDLE: `rx_ready`=1. On transfer, if N==0 or N>MAX_WORDS go to ERR. Otherwise latch N, clear word index and byte index, go to LOAD.
  - LOAD: `rx_ready`=1. Each transfer places the byte into lane `byte_idx` of the assembly register and increments `byte_idx` (2-bit, wraps). On the 4th byte (`byte_idx`==3), go to WRITE.
  - WRITE: `rx_ready`=0, `we`=1, `waddr`=word index, `wdata`=assembled word. Next cycle, increment word index. If the written word was word N-1, go to DONE; else go to LOAD.
  - DONE: `rx_ready`=0, `cpu_hold`=0, `done`=1. Remains here until `reset`.
  - ERR: `rx_ready`=0, `cpu_hold`=1, `err`=1. Remains here until `reset`.
- `we`, `waddr`, `wdata`, `cpu_hold`, `done`, and `err` are registered. `rx_ready` is decoded from state.
- Word index is ADDR_W+1 bits wide internally, so N=64 does not alias. `waddr` carries the low ADDR_W bits, which are never ≥ N.
- Bytes offered in DONE or ERR are not accepted (`rx_ready`=0). The source must hold or drop them.
- `reset` in any state, including mid-word: return to IDLE and discard the partial word and count. Memory contents already written are not cleared. `cpu_hold` reasserts.

## Timing
- Reset values: `rx_ready`=1 (IDLE), `we`=0, `waddr`=0, `wdata`=0, `cpu_hold`=1, `done`=0, `err`=0.
- Header byte accepted at edge t: `rx_ready` is 1 in the cycle following edge t (state LOAD).
- 4th byte of a word accepted at edge k: during cycle k→k+1, `we`=1 with `waddr`/`wdata` stable and `rx_ready`=0. The memory captures the word at edge k+1. `we` is low again after edge k+1.
- With `rx_valid` held high, a word takes 5 cycles (4 bytes + 1 write). The minimum load time is 1 + 5·N cycles from the first accept.
- Final write at edge f: `done`=1 and `cpu_hold`=0 from edge f onward, i.e. in the cycle after the `we` pulse. `we` is never high in the same cycle as `done`.
- Bad header accepted at edge t: `err`=1 from edge t. `rx_ready`=0 after edge t.
- `rx_valid` gaps of any length inside a word: no effect other than delay. No timeout.
- `reset` asserted at edge r takes priority over any transfer at edge r.

## Test plan
- Header 02, then bytes 0F 00 4F E0 0F 10 4F E0 with `rx_valid` held high. Required: `we` pulse at `waddr`=0 with `wdata`=E04F000F, then at `waddr`=1 with E04F100F, exactly 5 cycles apart. `done`=1 and `cpu_hold`=0 the cycle after the 2nd pulse. `rx_ready`=0 thereafter.
- Header 00, and separately header 41 (65 decimal). Required: `err`=1 next cycle, no `we` pulse, `cpu_hold` stays 1, and further bytes are not accepted.
- Header 01 with random 0–3 cycle `rx_valid` gaps between bytes 00 00 A0 E1. Required: a single `we` pulse, `waddr`=0, `wdata`=E1A00000.
- Header 02, 6 data bytes, assert `reset` for one cycle, then a fresh stream with header 01 and bytes 01 10 81 E2. Required: no write from the partial second word. The new write lands at `waddr`=0 with `wdata`=E2811001, and `done`=1 afterward.
- Header 40 (64 decimal) and 256 bytes encoding word i = i. Required: 64 pulses, `waddr` 0..63 in order, last `wdata`=0000003F, and `done` asserted only after `waddr`=63.
- After `done`, drive `rx_valid`=1 with `rx_data`=FF for 10 cycles. Required: `rx_ready`=0, no `we` pulse, and `done`/`cpu_hold` unchanged.
